// File: rtl/pic_port_uart_tx_if.sv
// Port-side bundle between the PIC16F54 GPIO pins and the UART transmitter.
// master = core side, slave = transmitter side.
interface pic_port_uart_tx_if;
    logic [7:0] port_data;
    logic [7:0] data_tris;
    logic       port_strb;
    logic       err_clr;
    logic [3:0] status;
    logic       txd;

    modport master (
        output port_data, data_tris, port_strb, err_clr,
        input  status, txd
    );

    modport slave (
        input  port_data, data_tris, port_strb, err_clr,
        output status, txd
    );
endinterface

// File: rtl/pic_port_uart_tx.sv
// PORTB byte capture into a FIFO, shifted out as UART on txd.
// Optional PIC_UART_TX_PARITY_EN adds an even-parity bit (8E1).
module pic_port_uart_tx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 4
) (
    input logic               clk,
    input logic               rst,
    pic_port_uart_tx_if.slave bus
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] BAUD_END = BW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef PIC_UART_TX_PARITY_EN
        PAR,
`endif
        STOP
    } state_t;

    state_t        state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shreg_q, shreg_d;
    logic          txd_q, txd_d;
    logic          strb_q;
    logic          ovf_q, tris_err_q, full_q, busy_q;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count_q, count_d;
`ifdef PIC_UART_TX_PARITY_EN
    logic          par_q, par_d;
`endif

    logic write_ev, tris_bad, full_now;
    logic push, pop, ovf_set, baud_end, fifo_nz;

    assign write_ev = bus.port_strb ^ strb_q;
    assign tris_bad = write_ev && (bus.data_tris != 8'h00);
    assign full_now = (count_q == DEPTH_C);
    assign ovf_set  = write_ev && !tris_bad && full_now;
    assign push     = write_ev && !tris_bad && !full_now;
    assign baud_end = (baud_q == BAUD_END);
    assign fifo_nz  = (count_q != '0);

    always_comb begin
        count_d = count_q;
        unique case (1'b1)
            push && !pop: count_d = count_q + CW'(1);
            !push && pop: count_d = count_q - CW'(1);
            default:      count_d = count_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        txd_d   = txd_q;
        pop     = 1'b0;
`ifdef PIC_UART_TX_PARITY_EN
        par_d   = par_q;
`endif
        unique case (state_q)
            IDLE: begin
                txd_d = 1'b1;
                if (fifo_nz) begin
                    pop     = 1'b1;
                    shreg_d = mem[rd_ptr];
`ifdef PIC_UART_TX_PARITY_EN
                    par_d   = ^mem[rd_ptr];
`endif
                    state_d = START;
                    baud_d  = '0;
                    txd_d   = 1'b0;
                end
            end
            START: begin
                baud_d = baud_q + BW'(1);
                if (baud_end) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = DATA;
                    txd_d   = shreg_q[0];
                end
            end
            DATA: begin
                baud_d = baud_q + BW'(1);
                if (baud_end) begin
                    baud_d  = '0;
                    shreg_d = {1'b0, shreg_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    txd_d   = shreg_q[1];
                    if (bit_q == 3'd7) begin
`ifdef PIC_UART_TX_PARITY_EN
                        state_d = PAR;
                        txd_d   = par_q;
`else
                        state_d = STOP;
                        txd_d   = 1'b1;
`endif
                    end
                end
            end
`ifdef PIC_UART_TX_PARITY_EN
            PAR: begin
                baud_d = baud_q + BW'(1);
                if (baud_end) begin
                    baud_d  = '0;
                    state_d = STOP;
                    txd_d   = 1'b1;
                end
            end
`endif
            STOP: begin
                baud_d = baud_q + BW'(1);
                if (baud_end) begin
                    baud_d = '0;
                    // Back-to-back frames: reload straight into START
                    if (fifo_nz) begin
                        pop     = 1'b1;
                        shreg_d = mem[rd_ptr];
`ifdef PIC_UART_TX_PARITY_EN
                        par_d   = ^mem[rd_ptr];
`endif
                        state_d = START;
                        txd_d   = 1'b0;
                    end else begin
                        state_d = IDLE;
                        txd_d   = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                txd_d   = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= bus.port_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            baud_q     <= '0;
            bit_q      <= '0;
            shreg_q    <= '0;
            txd_q      <= 1'b1;
            strb_q     <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count_q    <= '0;
            ovf_q      <= 1'b0;
            tris_err_q <= 1'b0;
            full_q     <= 1'b0;
            busy_q     <= 1'b0;
`ifdef PIC_UART_TX_PARITY_EN
            par_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_q      <= bit_d;
            shreg_q    <= shreg_d;
            txd_q      <= txd_d;
            strb_q     <= bus.port_strb;
            count_q    <= count_d;
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            // Set beats clear when both land on the same edge
            ovf_q      <= ovf_set  | (ovf_q      & ~bus.err_clr);
            tris_err_q <= tris_bad | (tris_err_q & ~bus.err_clr);
            full_q     <= (count_d == DEPTH_C);
            busy_q     <= (state_d != IDLE) || (count_d != '0);
`ifdef PIC_UART_TX_PARITY_EN
            par_q      <= par_d;
`endif
        end
    end

    assign bus.status = {ovf_q, tris_err_q, full_q, busy_q};
    assign bus.txd    = txd_q;
endmodule

// File: tb/tb_pic_port_uart_tx.sv
// Directed bench for pic_port_uart_tx (CLKS_PER_BIT=4, FIFO_DEPTH=4).
// Parity checks run only when PIC_UART_TX_PARITY_EN is defined.
module tb_pic_port_uart_tx;
    localparam int CPB = 4;
`ifdef PIC_UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic clk = 1'b0;
    logic rst;
    int   n_vec = 0;
    int   n_bad = 0;

    pic_port_uart_tx_if bus ();

    pic_port_uart_tx #(
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic wr(input logic [7:0] d);
        bus.port_data = d;
        bus.port_strb = ~bus.port_strb;
        @(negedge clk);
    endtask

    // Starts at the first negedge where the start bit is on txd.
    task automatic check_frame(input logic [7:0] b, input string tag);
        logic exp_bits [NB];
        exp_bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) exp_bits[i+1] = b[i];
`ifdef PIC_UART_TX_PARITY_EN
        exp_bits[9] = ^b;
`endif
        exp_bits[NB-1] = 1'b1;
        for (int i = 0; i < NB; i++) begin
            for (int k = 0; k < CPB; k++) begin
                chk($sformatf("%s_bit%0d_%0d", tag, i, k),
                    32'(bus.txd), 32'(exp_bits[i]));
                chk($sformatf("%s_busy%0d_%0d", tag, i, k),
                    32'(bus.status[0]), 32'd1);
                @(negedge clk);
            end
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "timeout");
    end

    initial begin
        int bad;
        rst           = 1'b1;
        bus.port_data = 8'h00;
        bus.data_tris = 8'h00;
        bus.port_strb = 1'b0;
        bus.err_clr   = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        chk("rst_txd", 32'(bus.txd), 32'd1);
        chk("rst_status", 32'(bus.status), 32'h0);
        bad = 0;
        repeat (100) begin
            @(negedge clk);
            if (bus.txd !== 1'b1 || bus.status !== 4'h0) bad++;
        end
        chk("idle_quiet", 32'(bad), 32'd0);

        // single frame; port_data changes after the push edge
        wr(8'hA5);
        chk("push_busy", 32'(bus.status), 32'h1);
        bus.port_data = 8'h00;
        @(negedge clk);
        check_frame(8'hA5, "a5");
        chk("a5_done", 32'(bus.status), 32'h0);
        chk("a5_idle_txd", 32'(bus.txd), 32'd1);

        // six writes on consecutive clocks, FIFO overflow
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    wr(8'(i + 1));
                    if (i == 4) chk("full_set", 32'(bus.status[1]), 32'd1);
                end
                chk("ovf_set", 32'(bus.status[3]), 32'd1);
            end
            begin
                @(negedge clk);
                @(negedge clk);
                for (int j = 1; j <= 5; j++)
                    check_frame(8'(j), $sformatf("b2b%0d", j));
            end
        join
        chk("b2b_end", 32'(bus.status), 32'h8);
        chk("b2b_txd", 32'(bus.txd), 32'd1);
        bus.err_clr = 1'b1;
        @(negedge clk);
        bus.err_clr = 1'b0;
        chk("ovf_clr", 32'(bus.status), 32'h0);

        // PORTB not driven by the core
        bus.data_tris = 8'hFF;
        wr(8'h55);
        chk("tris_err", 32'(bus.status), 32'h4);
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.txd !== 1'b1 || bus.status[0] !== 1'b0) bad++;
        end
        chk("tris_no_frame", 32'(bad), 32'd0);
        bus.err_clr = 1'b1;
        @(negedge clk);
        bus.err_clr = 1'b0;
        bus.data_tris = 8'h00;
        chk("tris_clr", 32'(bus.status), 32'h0);

        // reset during data bit 3 with a byte queued behind it
        wr(8'hA5);
        @(negedge clk);
        chk("mid_start", 32'(bus.txd), 32'd0);
        wr(8'h3C);
        repeat (16) @(negedge clk);
        chk("mid_bit3", 32'(bus.txd), 32'd0);
        chk("mid_full", 32'(bus.status), 32'h1);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_txd", 32'(bus.txd), 32'd1);
        chk("mid_rst_status", 32'(bus.status), 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        bad = 0;
        repeat (60) begin
            @(negedge clk);
            if (bus.txd !== 1'b1 || bus.status !== 4'h0) bad++;
        end
        chk("post_rst_quiet", 32'(bad), 32'd0);

`ifdef PIC_UART_TX_PARITY_EN
        wr(8'h07);
        @(negedge clk);
        check_frame(8'h07, "par07");
        chk("par07_done", 32'(bus.status), 32'h0);
        wr(8'h03);
        @(negedge clk);
        check_frame(8'h03, "par03");
        chk("par03_done", 32'(bus.status), 32'h0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/pic_port_uart_tx.md
Name: pic_port_uart_tx

Overview:
- Serial transmitter peripheral that sits on the PIC16F54 core's GPIO pins and is the reading end of the core's port-write interface.
- Firmware places a byte on PORTB and toggles PORTA bit 0. The block captures the byte into a small FIFO and shifts it out as 8N1 UART on txd.
- Status is returned to the core through PORTA inputs.
- The block runs on the same clk as the core, so no synchronisers are needed.

Parameters:
- CLKS_PER_BIT, 868, clk cycles per serial bit (100 MHz / 115200); must be >= 2.
- FIFO_DEPTH, 4, byte entries; must be a power of 2 and >= 2.

Ports:
- clk  in  1  system clock, rising-edge.
- rst  in  1  reset, asynchronous, active-high.
- port_data  in  8  byte from core portb_out.
- data_tris  in  8  core portb_tris; 8'h00 means all PORTB pins are outputs.
- port_strb  in  1  write strobe from porta_out[0]; toggle protocol.
- err_clr  in  1  from porta_out[1]; level-high clears the sticky error flags.
- status  out  4  to porta_in: {ovf, tris_err, full, busy}.
- txd  out  1  UART serial output; idle high.

Behaviour:
- Reset, asynchronous:
  - txd=1, status=4'b0000, FSM=IDLE.
  - FIFO emptied; strb_q=0; bit counter and baud counter = 0.
- Strobe detect:
  - strb_q registers port_strb every clk.
  - write_ev = port_strb ^ strb_q. Every toggle is one write; the polarity of the level is irrelevant.
- Write handling, on the clk edge where write_ev=1 (priority order):
  - data_tris != 8'h00: byte dropped, tris_err set.
  - FIFO full (count == FIFO_DEPTH, evaluated before any same-cycle pop): byte dropped, ovf set.
  - Otherwise: port_data pushed.
- Sticky flags:
  - ovf and tris_err hold until a cycle with err_clr=1.
  - If set and clear occur in the same cycle, set wins.
- full = (count == FIFO_DEPTH).
- busy = FSM != IDLE, or FIFO not empty.
- All status bits are registered (reflect state after the edge).
- Push/pop on the same edge with 0 < count < FIFO_DEPTH: count unchanged, both take effect.
- FIFO pointers wrap modulo FIFO_DEPTH. Count width is log2(FIFO_DEPTH)+1.
- TX FSM states: IDLE, START, DATA, PAR (only with option), STOP.
  - IDLE: txd=1. If FIFO is non-empty, pop into shift register, go to START, baud counter=0.
  - START: txd=0 for CLKS_PER_BIT clks.
  - DATA: 8 bits, LSB first, each held CLKS_PER_BIT clks. Bit index 0..7; after bit 7 go to STOP (or PAR).
  - STOP: txd=1 for CLKS_PER_BIT clks. At the end, if the FIFO is non-empty, pop and go directly to START (no idle gap); else go to IDLE.
- txd is a registered output; no glitches.
- Latency: toggle sampled at edge N → push at N → pop at N+1. txd is low from edge N+1 through edge N+1+CLKS_PER_BIT.
- Frame length: 10*CLKS_PER_BIT clks (11 with parity).
- Byte on port_data is captured at the push edge; later changes do not affect a queued byte.
- Reset mid-frame: txd returns high immediately; the partial frame is aborted and queued bytes are lost.
- Writes during a frame are accepted into the FIFO normally.

Optional Feature:
- Macro: PIC_UART_TX_PARITY_EN.
- Defined:
  - PAR state is inserted after DATA; txd = even parity (XOR of the 8 data bits) for CLKS_PER_BIT clks.
  - Frame = 11*CLKS_PER_BIT.
- Undefined:
  - PAR state and parity logic are absent.
  - 8N1 framing, frame = 10*CLKS_PER_BIT.

Test Plan (CLKS_PER_BIT=4, FIFO_DEPTH=4):
1. Assert rst, hold 5 clks, release → txd=1, status=4'b0000, and txd stays high with no strobe activity for 100 clks.
2. data_tris=8'h00, port_data=8'hA5, toggle port_strb once:
   - txd low 4 clks, then bits 1,0,1,0,0,1,0,1 (4 clks each), stop high 4 clks; 40 clks total.
   - busy=1 throughout the frame, 0 after.
3. Six toggles on consecutive clks with bytes 8'h01..8'h06:
   - 8'h01 popped immediately; 8'h02..8'h05 queued; 8'h06 dropped; ovf=1; full=1 after the 5th write.
   - Five back-to-back frames, 200 clks, with no idle gap.
   - Pulse err_clr → ovf=0.
4. data_tris=8'hFF, toggle with port_data=8'h55 → no frame, tris_err=1, busy=0. err_clr=1 for 1 clk → tris_err=0.
5. Start the 8'hA5 frame, assert rst during DATA bit 3 → txd=1 within the same cycle, status=0. After release, no further frame.
6. With PIC_UART_TX_PARITY_EN defined, send 8'h07 → parity bit=1, stop bit follows, frame 44 clks. Send 8'h03 → parity bit=0.
